// File: rtl/byte_word_packer_pkg.sv
// Shared definitions for the byte-to-word packer: byte width, lane index
// type, byte-count width helper and the zero-pad mask used on flush.
package byte_word_packer_pkg;

  localparam int BYTE_W    = 8;
  localparam int MAX_BYTES = 8;

  // Lane index wide enough for the largest legal word (8 lanes)
  typedef logic [2:0] lane_idx_t;

  // All-ones reference word; shifted right to keep only the filled lanes
  localparam logic [MAX_BYTES*BYTE_W-1:0] PAD_MASK_ALL = '1;

  // Width needed to hold a byte count of 0..n_bytes
  function automatic int calc_cnt_w(input int n_bytes);
    return $clog2(n_bytes + 1);
  endfunction

  // Mask with ones in the lowest n_lanes byte lanes, zeros above
  function automatic logic [MAX_BYTES*BYTE_W-1:0] pad_mask(input int n_lanes);
    if (n_lanes >= MAX_BYTES) begin
      return PAD_MASK_ALL;
    end
    return PAD_MASK_ALL >> (BYTE_W * (MAX_BYTES - n_lanes));
  endfunction

endpackage

// File: rtl/byte_word_packer_if.sv
// Bus bundle for the packer: read side towards the byte store stage,
// word side towards the consumer, plus flush control and status.
// The master modport is the packer's view, slave is its environment.
interface byte_word_packer_if
  import byte_word_packer_pkg::*;
#(
  parameter int N_BYTES = 4,
  parameter int CNT_W   = calc_cnt_w(N_BYTES)
);

  logic                      rd_req;
  logic                      byte_oe;
  logic [BYTE_W-1:0]         byte_in;
  logic                      flush;
  logic [BYTE_W*N_BYTES-1:0] word_out;
  logic [CNT_W-1:0]          word_bytes;
  logic                      word_valid;
  logic                      word_ready;
  logic                      flush_done;
  logic                      err;

  modport master (
    output rd_req,
    input  byte_oe,
    input  byte_in,
    input  flush,
    output word_out,
    output word_bytes,
    output word_valid,
    input  word_ready,
    output flush_done,
    output err
  );

  modport slave (
    input  rd_req,
    output byte_oe,
    output byte_in,
    output flush,
    input  word_out,
    input  word_bytes,
    input  word_valid,
    output word_ready,
    input  flush_done,
    input  err
  );

endinterface

// File: rtl/byte_word_packer_out_reg.sv
// Valid/ready holding register for the packed word. A load always wins;
// otherwise the word is dropped once the consumer accepts it. Contents are
// frozen while valid is high and ready is low.
module packer_out_reg
  import byte_word_packer_pkg::*;
#(
  parameter int DATA_W = BYTE_W * 4,
  parameter int CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_word,
  input  logic [CNT_W-1:0]  load_bytes,
  input  logic              ready,
  output logic [DATA_W-1:0] word_q,
  output logic [CNT_W-1:0]  bytes_q,
  output logic              valid_q,
  output logic              can_load
);

  assign can_load = !valid_q || ready;

  // Load a new word, or retire the current one when the consumer takes it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_q  <= '0;
      bytes_q <= '0;
      valid_q <= 1'b0;
    end else if (load) begin
      word_q  <= load_word;
      bytes_q <= load_bytes;
      valid_q <= 1'b1;
    end else if (valid_q && ready) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/byte_word_packer.sv
// Byte-to-word packer. Requests bytes from the single-byte store stage,
// captures each one the cycle after its output_enable, assembles them
// little-endian and hands complete (or flushed partial) words downstream.
// Requests are throttled so the word-completing byte can always be loaded.
module byte_word_packer
  import byte_word_packer_pkg::*;
#(
  parameter int N_BYTES = 4,
  parameter int CNT_W   = calc_cnt_w(N_BYTES)
) (
  input logic                clk,
  input logic                rst,
  byte_word_packer_if.master bus
);

  localparam int               WORD_W     = BYTE_W * N_BYTES;
  localparam logic [CNT_W-1:0] LAST_LANE  = CNT_W'(N_BYTES - 1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(N_BYTES);
  localparam logic [CNT_W:0]   OCC_LIMIT  = (CNT_W + 1)'(N_BYTES - 1);

  logic [CNT_W-1:0]  cnt;
  logic              pend;
  logic [WORD_W-1:0] asm_word;
  logic              flush_pend;
  logic              flush_done_q;
  logic              err_q;

  logic [CNT_W:0]    occ;
  logic              rd_req;
  logic              word_full;
  logic              flush_cond;
  logic              load;
  lane_idx_t         lane;
  logic [WORD_W-1:0] merged_word;
  logic [WORD_W-1:0] load_word;
  logic [CNT_W-1:0]  load_bytes;

  logic              can_load;
  logic              out_valid;
  logic [WORD_W-1:0] out_word;
  logic [CNT_W-1:0]  out_bytes;

  // Bytes already held or in flight; with a stalled output we stop one short
  // of a full word so the completing byte never meets a busy register.
  assign occ    = {1'b0, cnt} + {{CNT_W{1'b0}}, pend};
  assign rd_req = !flush_pend && (!out_valid || (occ < OCC_LIMIT));

  assign word_full  = pend && (cnt == LAST_LANE);
  assign flush_cond = flush_pend && !pend && can_load;
  assign load       = word_full || (flush_cond && (cnt != '0));
  assign lane       = lane_idx_t'(cnt);

  // Assembly buffer with the returning byte dropped into its lane
  always_comb begin
    merged_word = asm_word;
    merged_word[lane*BYTE_W +: BYTE_W] = bus.byte_in;
  end

  // Select between a completed word and a zero-padded flush remnant
  always_comb begin
    if (word_full) begin
      load_word  = merged_word;
      load_bytes = FULL_COUNT;
    end else begin
      load_word  = asm_word & WORD_W'(pad_mask(int'(cnt)));
      load_bytes = cnt;
    end
  end

  // Capture pipeline: track the in-flight byte and fill the assembly buffer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend     <= 1'b0;
      cnt      <= '0;
      asm_word <= '0;
    end else begin
      pend <= bus.byte_oe && rd_req;
      if (word_full) begin
        cnt      <= '0;
        asm_word <= '0;
      end else if (pend) begin
        cnt      <= cnt + CNT_W'(1);
        asm_word <= merged_word;
      end else if (flush_cond) begin
        cnt      <= '0;
        asm_word <= '0;
      end
    end
  end

  // Flush handshake and sticky protocol-error flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flush_pend   <= 1'b0;
      flush_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      flush_done_q <= flush_cond;
      if (flush_cond) begin
        flush_pend <= 1'b0;
      end else if (bus.flush) begin
        flush_pend <= 1'b1;
      end
      if (bus.byte_oe && !rd_req) begin
        err_q <= 1'b1;
      end
    end
  end

  packer_out_reg #(
    .DATA_W (WORD_W),
    .CNT_W  (CNT_W)
  ) u_out_reg (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_word  (load_word),
    .load_bytes (load_bytes),
    .ready      (bus.word_ready),
    .word_q     (out_word),
    .bytes_q    (out_bytes),
    .valid_q    (out_valid),
    .can_load   (can_load)
  );

  assign bus.rd_req     = rd_req;
  assign bus.word_out   = out_word;
  assign bus.word_bytes = out_bytes;
  assign bus.word_valid = out_valid;
  assign bus.flush_done = flush_done_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_byte_word_packer.sv
// Directed self-checking bench for byte_word_packer with N_BYTES=4.
// A queue models the store stage: each accepted byte_oe returns the next
// byte on byte_in one cycle later. Accepted words are logged at negedge.
module tb_byte_word_packer;
  import byte_word_packer_pkg::*;

  localparam int N_BYTES = 4;
  localparam int CNT_W   = calc_cnt_w(N_BYTES);

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  logic [7:0]       src_q[$];
  logic [31:0]      got_word_q[$];
  logic [CNT_W-1:0] got_bytes_q[$];

  byte_word_packer_if #(.N_BYTES(N_BYTES)) bus ();

  byte_word_packer #(.N_BYTES(N_BYTES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Record every word the consumer accepts
  always @(negedge clk) begin
    if (rst === 1'b1 && bus.word_valid === 1'b1 && bus.word_ready === 1'b1) begin
      got_word_q.push_back(bus.word_out);
      got_bytes_q.push_back(bus.word_bytes);
    end
  end

  // Hard stop if the sequence ever stalls
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One clock of stimulus; a granted byte_oe returns the next source byte
  task automatic applyStimulus(input logic oe, input logic fl, input logic rdy);
    bus.byte_oe    = oe;
    bus.flush      = fl;
    bus.word_ready = rdy;
    @(posedge clk);
    #1;
    if (oe && src_q.size() > 0) bus.byte_in = src_q.pop_front();
    bus.byte_oe = 1'b0;
    bus.flush   = 1'b0;
  endtask

  // Store stage that echoes rd_req while it still has bytes
  task automatic echoCycles(input int n, input logic rdy);
    for (int i = 0; i < n; i++) begin
      applyStimulus(bus.rd_req && (src_q.size() > 0), 1'b0, rdy);
    end
  endtask

  function automatic logic [63:0] gotWord(input int idx);
    if (got_word_q.size() > idx) return 64'(got_word_q[idx]);
    return 64'hDEAD_BEEF_DEAD_BEEF;
  endfunction

  function automatic logic [63:0] gotBytes(input int idx);
    if (got_bytes_q.size() > idx) return 64'(got_bytes_q[idx]);
    return 64'hDEAD;
  endfunction

  initial begin
    rst            = 1'b0;
    bus.byte_oe    = 1'b0;
    bus.byte_in    = 8'h00;
    bus.flush      = 1'b0;
    bus.word_ready = 1'b0;
    #2;
    checkOutput("rst_word_out",   64'(bus.word_out),   64'h0);
    checkOutput("rst_word_bytes", 64'(bus.word_bytes), 64'h0);
    checkOutput("rst_word_valid", 64'(bus.word_valid), 64'h0);
    checkOutput("rst_flush_done", 64'(bus.flush_done), 64'h0);
    checkOutput("rst_err",        64'(bus.err),        64'h0);
    checkOutput("rst_rd_req",     64'(bus.rd_req),     64'h1);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;

    // Back-to-back full word with the consumer always ready
    $display("[TB] test 1: full word, ready high");
    got_word_q.delete(); got_bytes_q.delete();
    src_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    repeat (4) applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("t1_valid_not_early", 64'(bus.word_valid), 64'h0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("t1_valid",      64'(bus.word_valid), 64'h1);
    checkOutput("t1_word_out",   64'(bus.word_out),   64'h44332211);
    checkOutput("t1_word_bytes", 64'(bus.word_bytes), 64'h4);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("t1_valid_drop", 64'(bus.word_valid), 64'h0);
    checkOutput("t1_got_count",  64'(got_word_q.size()), 64'h1);

    // Stalled consumer: first word holds, requests stop at three bytes
    $display("[TB] test 2: backpressure");
    got_word_q.delete(); got_bytes_q.delete();
    src_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    echoCycles(10, 1'b0);
    checkOutput("t2_valid_held", 64'(bus.word_valid), 64'h1);
    checkOutput("t2_word_held",  64'(bus.word_out),   64'h04030201);
    checkOutput("t2_rd_req_low", 64'(bus.rd_req),     64'h0);
    checkOutput("t2_src_left",   64'(src_q.size()),   64'h1);
    echoCycles(8, 1'b1);
    checkOutput("t2_got_count",  64'(got_word_q.size()), 64'h2);
    checkOutput("t2_word0",      gotWord(0),  64'h04030201);
    checkOutput("t2_word1",      gotWord(1),  64'h08070605);
    checkOutput("t2_bytes1",     gotBytes(1), 64'h4);
    checkOutput("t2_valid_idle", 64'(bus.word_valid), 64'h0);

    // Flush with two bytes assembled
    $display("[TB] test 3: partial flush");
    got_word_q.delete(); got_bytes_q.delete();
    src_q = '{8'hAA, 8'hBB};
    repeat (2) applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("t3_rd_req_blocked", 64'(bus.rd_req),     64'h0);
    checkOutput("t3_done_not_yet",   64'(bus.flush_done), 64'h0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("t3_flush_done",  64'(bus.flush_done), 64'h1);
    checkOutput("t3_valid",       64'(bus.word_valid), 64'h1);
    checkOutput("t3_word_out",    64'(bus.word_out),   64'h0000BBAA);
    checkOutput("t3_word_bytes",  64'(bus.word_bytes), 64'h2);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("t3_done_pulse",  64'(bus.flush_done), 64'h0);
    checkOutput("t3_rd_req_back", 64'(bus.rd_req),     64'h1);
    checkOutput("t3_got_count",   64'(got_word_q.size()), 64'h1);

    // Flush with nothing assembled
    $display("[TB] test 4: empty flush");
    got_word_q.delete(); got_bytes_q.delete();
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("t4_rd_req_blocked", 64'(bus.rd_req), 64'h0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("t4_flush_done", 64'(bus.flush_done), 64'h1);
    checkOutput("t4_no_valid",   64'(bus.word_valid), 64'h0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("t4_done_pulse", 64'(bus.flush_done), 64'h0);
    checkOutput("t4_got_count",  64'(got_word_q.size()), 64'h0);

    // Byte offered while requests are gated off
    $display("[TB] test 5: protocol error");
    got_word_q.delete(); got_bytes_q.delete();
    src_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
    echoCycles(10, 1'b0);
    checkOutput("t5_rd_req_low", 64'(bus.rd_req), 64'h0);
    checkOutput("t5_err_clear",  64'(bus.err),    64'h0);
    src_q.push_front(8'hEE);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("t5_err_set", 64'(bus.err), 64'h1);
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("t5_err_sticky", 64'(bus.err),      64'h1);
    checkOutput("t5_word_held",  64'(bus.word_out), 64'h13121110);
    echoCycles(8, 1'b1);
    checkOutput("t5_got_count", 64'(got_word_q.size()), 64'h2);
    checkOutput("t5_word0",     gotWord(0), 64'h13121110);
    checkOutput("t5_word1",     gotWord(1), 64'h17161514);
    checkOutput("t5_err_still", 64'(bus.err), 64'h1);

    // Asynchronous reset in the middle of a word
    $display("[TB] test 6: reset mid-word");
    src_q = '{8'hA1, 8'hA2};
    repeat (2) applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    #3 rst = 1'b0;
    #1;
    checkOutput("t6_err",        64'(bus.err),        64'h0);
    checkOutput("t6_word_out",   64'(bus.word_out),   64'h0);
    checkOutput("t6_word_bytes", 64'(bus.word_bytes), 64'h0);
    checkOutput("t6_valid",      64'(bus.word_valid), 64'h0);
    checkOutput("t6_flush_done", 64'(bus.flush_done), 64'h0);
    checkOutput("t6_rd_req",     64'(bus.rd_req),     64'h1);
    @(posedge clk);
    #1 rst = 1'b1;
    got_word_q.delete(); got_bytes_q.delete();
    src_q = '{8'h55, 8'h66, 8'h77, 8'h88};
    repeat (4) applyStimulus(1'b1, 1'b0, 1'b1);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("t6_got_count", 64'(got_word_q.size()), 64'h1);
    checkOutput("t6_word0",     gotWord(0),  64'h88776655);
    checkOutput("t6_bytes0",    gotBytes(0), 64'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/byte_word_packer.md
Name: byte_word_packer

Overview:
- Sits directly downstream of the single-byte store stage.
- Issues read requests to that stage and captures the byte it returns one cycle later.
- Packs N bytes, little-endian, into one word and presents it on a valid/ready output port.
- Supports a flush that emits a partial, zero-padded word, and backpressures the store stage so no byte is ever dropped.

Parameters:
- N_BYTES, 4, bytes per output word; legal range 2..8.
- CNT_W, $clog2(N_BYTES+1), width of the byte-count field.

Ports:
- clk  input  1  clock; all logic on rising edge
- rst  input  1  asynchronous, active-low reset; asserting low clears all state immediately
- rd_req  output  1  read request to the store stage's read_enable
- byte_oe  input  1  store stage's output_enable; the same-cycle echo of the read request
- byte_in  input  8  store stage's data_out; valid the cycle after byte_oe
- flush  input  1  single-cycle pulse: emit the partial word
- word_out  output  8*N_BYTES  packed word; lane 0 holds the first byte, bits [7:0]
- word_bytes  output  CNT_W  number of valid bytes in word_out (1..N_BYTES)
- word_valid  output  1  word_out/word_bytes valid
- word_ready  input  1  downstream accepts the word
- flush_done  output  1  one-cycle pulse when a flush completes
- err  output  1  sticky protocol-violation flag

Behaviour:
- Reset (rst=0): cnt=0, pend=0, asm=0, word_out=0, word_bytes=0, word_valid=0, flush_pend=0, flush_done=0, err=0.
  - rd_req is combinational and reads 1 while in reset.
- Capture pipeline:
  - pend <= byte_oe & rd_req.
  - When pend=1, byte_in is written to asm lane cnt, then cnt increments.
  - Latency from the final byte_oe to word_valid is 2 cycles.
- Word complete: on a capture with cnt==N_BYTES-1:
  - asm plus the new byte move to word_out; word_bytes=N_BYTES; word_valid=1.
  - cnt=0 and asm is cleared.
  - Legal when word_valid=0, or when word_valid&&word_ready in the same cycle.
- Output register:
  - word_valid holds until the cycle where word_valid&&word_ready; it then clears unless a new word loads that same cycle.
  - word_out and word_bytes are stable while word_valid&&!word_ready.
- Request gating, with occ = cnt + pend:
  - rd_req = !flush_pend && (!word_valid || occ < N_BYTES-1).
  - This guarantees that a word-completing capture never meets a stalled, full output register.
- Protocol error: byte_oe=1 while rd_req=0 sets err (sticky until reset). That byte is ignored: pend stays 0 and cnt is unchanged.
- Flush:
  - A flush pulse sets flush_pend, which forces rd_req=0.
  - Flush completes in the first cycle with pend=0 and (word_valid=0 or word_ready=1):
    - cnt>0: asm moves to word_out with unused lanes zero; word_bytes=cnt; word_valid=1; cnt=0.
    - cnt=0: no word is produced.
  - In either case flush_done pulses one cycle and flush_pend clears.
  - A flush arriving while flush_pend=1 merges into the pending flush.
- Simultaneous events:
  - A capture that completes a word in the same cycle as the flush-complete condition: the full word loads, and the flush completes with cnt=0 (no extra word).
  - A load in the same cycle as a drain (word_valid&&word_ready) keeps word_valid=1.
- Reset mid-word: the partial word is discarded; the next captured byte goes to lane 0.
- Arithmetic: cnt wraps only via an explicit clear; it never exceeds N_BYTES-1.

Decomposition:
- Shared package holds:
  - BYTE_W=8
  - the lane index type
  - a function computing CNT_W
  - a zero-pad mask constant
- One sub-module: packer_out_reg.
  - Valid/ready holding register for word_out, word_bytes and word_valid.
  - Exposes a load input, and a "can_load" output computed as !valid||ready.

Test Plan (N_BYTES=4):
1. byte_oe on 4 consecutive cycles returning 0x11,0x22,0x33,0x44, word_ready=1 -> word_out=0x44332211, word_bytes=4, word_valid high 1 cycle, 2 cycles after the last byte_oe.
2. word_ready=0, upstream echoes rd_req, bytes 0x01..0x08 ->
   - word_out holds 0x04030201.
   - rd_req drops once occ=3.
   - Raise word_ready -> 0x04030201 accepted, then 0x08070605; no byte lost or duplicated.
3. Bytes 0xAA,0xBB then flush -> word_out=0x0000BBAA, word_bytes=2, flush_done pulses 1 cycle; rd_req low until then.
4. Flush with cnt=0 and word_valid=0 -> flush_done next cycle, word_valid stays 0.
5. byte_oe=1 while word_valid=1 stalled and occ=3 (rd_req=0) -> err=1 and stays 1; cnt unchanged; next word content correct.
6. rst low after 2 captured bytes -> all outputs 0 immediately, without waiting for clk. After release, bytes 0x55,0x66,0x77,0x88 -> 0x88776655.
